mux_rr_flop: RTL and testbench

MUX_RR_FLOP -- requirements
Module: mux_rr_flop

---
 rtl/mux_rr_flop_pkg.sv | 22 ++
 rtl/mux_rr_flop_if.sv | 61 ++++++
 rtl/mux_rr_flop_rr_arbiter.sv | 39 +++
 rtl/mux_rr_flop.sv | 100 ++++++++++
 tb/tb_mux_rr_flop.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_flop_pkg.sv
// rtl/mux_rr_flop_pkg.sv - shared defaults and mode encodings for the mux_rr_flop slice
//
// Purpose : default channel geometry, mode encoding and counter width used by
//           the interface, the arbiter and the top-level register stage.
// Ports   : none (package).

package mux_rr_flop_pkg;

   // Default geometry: 4 channels of 8 bits each.
   localparam int DEF_WIDTH    = 8;
   localparam int DEF_CHANNELS = 4;

   // Width of the grant counter; it wraps 255 -> 0.
   localparam int COUNT_W = 8;

   // Operating mode carried on the single-bit mode input.
   typedef enum logic {
      MODE_FIXED = 1'b0,   // registered mux on the fixed selector
      MODE_RR    = 1'b1    // round-robin over valid channels
   } mode_e;

endpackage

// File: rtl/mux_rr_flop_if.sv
// rtl/mux_rr_flop_if.sv - channel/handshake bundle between a source and mux_rr_flop
//
// Purpose : groups the packed channel data, per-channel valids, control inputs
//           and the registered outputs of mux_rr_flop.
// Ports   : none; signals
//           dataIn     [CHANNELS*WIDTH] packed channels, channel i at [i*WIDTH +: WIDTH]
//           validIn    [CHANNELS]       per-channel valid
//           selector   [SEL_W]          fixed channel index (fixed mode only)
//           mode       [1]              0 fixed-select, 1 round-robin
//           enable     [1]              1 update registers, 0 hold
//           dataOut    [WIDTH]          registered selected data
//           validOut   [1]              registered valid of selected channel
//           selOut     [SEL_W]          registered index loaded into dataOut
//           grantCount [8]              registered count of validOut=1 loads
// Modports: master drives the inputs of the mux, slave is the mux itself.

interface mux_rr_flop_if
   import mux_rr_flop_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS
) ();

   localparam int SEL_W = $clog2(CHANNELS);

   logic [CHANNELS*WIDTH-1:0] dataIn;
   logic [CHANNELS-1:0]       validIn;
   logic [SEL_W-1:0]          selector;
   logic                      mode;
   logic                      enable;

   logic [WIDTH-1:0]          dataOut;
   logic                      validOut;
   logic [SEL_W-1:0]          selOut;
   logic [COUNT_W-1:0]        grantCount;

   modport master (
      output dataIn,
      output validIn,
      output selector,
      output mode,
      output enable,
      input  dataOut,
      input  validOut,
      input  selOut,
      input  grantCount
   );

   modport slave (
      input  dataIn,
      input  validIn,
      input  selector,
      input  mode,
      input  enable,
      output dataOut,
      output validOut,
      output selOut,
      output grantCount
   );

endinterface

// File: rtl/mux_rr_flop_rr_arbiter.sv
// rtl/mux_rr_flop_rr_arbiter.sv - combinational round-robin search over channel valids
//
// Purpose : starting at ptr and walking ptr, ptr+1, ... modulo CHANNELS, report
//           the first index whose valid bit is set.
// Ports   : validIn    in  [CHANNELS] per-channel valid
//           ptr        in  [SEL_W]    search start index
//           grantIdx   out [SEL_W]    first valid index found (0 when none)
//           grantFound out [1]        1 when any channel is valid

module rr_arbiter
   import mux_rr_flop_pkg::*;
#(
   parameter  int CHANNELS = DEF_CHANNELS,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] validIn,
   input  logic [SEL_W-1:0]    ptr,
   output logic [SEL_W-1:0]    grantIdx,
   output logic                grantFound
);

   logic [SEL_W-1:0] probeIdx;

   // CHANNELS is a power of two, so the SEL_W-bit add wraps the search
   // naturally back to index 0 without an explicit modulo.
   always_comb begin
      grantIdx   = '0;
      grantFound = 1'b0;
      probeIdx   = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         probeIdx = ptr + SEL_W'(k);
         if (!grantFound && validIn[probeIdx]) begin
            grantFound = 1'b1;
            grantIdx   = probeIdx;
         end
      end
   end

endmodule

// File: rtl/mux_rr_flop.sv
// rtl/mux_rr_flop.sv - registered channel mux with fixed-select and round-robin modes
//
// Purpose : selects one of CHANNELS packed data channels, either by a fixed
//           selector or by round-robin over valid channels, and registers the
//           result with one clock of latency. Counts cycles that load a valid.
// Ports   : clk   in  1  clock, rising edge
//           reset in  1  synchronous active-high reset, dominates everything
//           bus   mux_rr_flop_if.slave  data/valid/control in, registered out
// Note    : WIDTH and CHANNELS must match the parameters of the connected bus.

module mux_rr_flop
   import mux_rr_flop_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int CHANNELS = DEF_CHANNELS,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic               clk,
   input  logic               reset,
   mux_rr_flop_if.slave       bus
);

   // Unpacked view of the packed channel bus.
   logic [WIDTH-1:0]   chan [CHANNELS];

   logic [SEL_W-1:0]   ptr;          // next round-robin search start
   logic [SEL_W-1:0]   grantIdx;
   logic               grantFound;

   mode_e              modeNow;
   logic [SEL_W-1:0]   loadIdx;      // channel that this edge would load
   logic               loadValid;    // this edge would load validOut=1
   logic               loadData;     // this edge updates dataOut/selOut
   logic [WIDTH-1:0]   muxData;

   logic [WIDTH-1:0]   dataOutQ;
   logic               validOutQ;
   logic [SEL_W-1:0]   selOutQ;
   logic [COUNT_W-1:0] grantCountQ;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      assign chan[g] = bus.dataIn[g*WIDTH +: WIDTH];
   end

   assign modeNow = mode_e'(bus.mode);

   rr_arbiter #(
      .CHANNELS   (CHANNELS)
   ) u_arbiter (
      .validIn    (bus.validIn),
      .ptr        (ptr),
      .grantIdx   (grantIdx),
      .grantFound (grantFound)
   );

   // Fixed mode always loads the selected channel, valid or not; round-robin
   // only loads data when the search found something, otherwise dataOut and
   // selOut keep their last grant.
   always_comb begin
      loadIdx   = bus.selector;
      loadValid = bus.validIn[bus.selector];
      loadData  = 1'b1;
      if (modeNow == MODE_RR) begin
         loadIdx   = grantIdx;
         loadValid = grantFound;
         loadData  = grantFound;
      end
      muxData = chan[loadIdx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dataOutQ    <= '0;
         validOutQ   <= 1'b0;
         selOutQ     <= '0;
         grantCountQ <= '0;
         ptr         <= '0;
      end else if (bus.enable) begin
         validOutQ <= loadValid;
         if (loadData) begin
            dataOutQ <= muxData;
            selOutQ  <= loadIdx;
         end
         if (loadValid) begin
            grantCountQ <= grantCountQ + COUNT_W'(1);
         end
         // ptr only advances on a round-robin grant; fixed mode leaves it
         // untouched so switching back resumes where the search left off.
         if (modeNow == MODE_RR && grantFound) begin
            ptr <= grantIdx + SEL_W'(1);
         end
      end
   end

   assign bus.dataOut    = dataOutQ;
   assign bus.validOut   = validOutQ;
   assign bus.selOut     = selOutQ;
   assign bus.grantCount = grantCountQ;

endmodule

// File: tb/tb_mux_rr_flop.sv
// tb/tb_mux_rr_flop.sv - self-checking bench for mux_rr_flop (CHANNELS=4, WIDTH=8)

module tb_mux_rr_flop;
   import mux_rr_flop_pkg::*;

   localparam int W = 8;
   localparam int C = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mux_rr_flop_if #(.WIDTH(W), .CHANNELS(C)) bus ();

   mux_rr_flop #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int nChecks = 0;
   int nFails  = 0;

   // Reference model state, plain integers.
   int mData, mValid, mSel, mCount, mPtr;

   typedef struct {
      logic        rst;
      logic        en;
      logic        md;
      logic [1:0]  sel;
      logic [3:0]  vin;
      logic [31:0] data;
      logic [7:0]  eData;
      logic        eValid;
      logic [1:0]  eSel;
      logic [7:0]  eCount;
      logic [1:0]  ePtr;
   } vector_t;

   vector_t vec[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int chanOf(input logic [31:0] d, input int i);
      return int'((d >> (W * i)) & 32'hFF);
   endfunction

   // Behavioural model of one rising edge using the current inputs.
   task automatic modelEdge();
      int s, i;
      bit found;
      if (reset) begin
         mData = 0; mValid = 0; mSel = 0; mCount = 0; mPtr = 0;
      end else if (bus.enable) begin
         if (bus.mode == 1'b0) begin
            s      = int'(bus.selector);
            mData  = chanOf(bus.dataIn, s);
            mValid = int'(bus.validIn[s]);
            mSel   = s;
            if (mValid == 1) mCount = (mCount + 1) % 256;
         end else begin
            found = 0;
            i     = 0;
            for (int k = 0; k < C && !found; k++) begin
               i = (mPtr + k) % C;
               if (bus.validIn[i]) found = 1;
            end
            if (found) begin
               mData  = chanOf(bus.dataIn, i);
               mValid = 1;
               mSel   = i;
               mPtr   = (i + 1) % C;
               mCount = (mCount + 1) % 256;
            end else begin
               mValid = 0;
            end
         end
      end
   endtask

   task automatic tick();
      modelEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic checkModel(input string tag);
      chk({tag, ".dataOut"},    32'(bus.dataOut),    32'(mData));
      chk({tag, ".validOut"},   32'(bus.validOut),   32'(mValid));
      chk({tag, ".selOut"},     32'(bus.selOut),     32'(mSel));
      chk({tag, ".grantCount"}, 32'(bus.grantCount), 32'(mCount));
      chk({tag, ".ptr"},        32'(dut.ptr),        32'(mPtr));
   endtask

   task automatic drive(input logic rst, input logic en, input logic md,
                        input logic [1:0] sel, input logic [3:0] vin, input logic [31:0] d);
      reset        = rst;
      bus.enable   = en;
      bus.mode     = md;
      bus.selector = sel;
      bus.validIn  = vin;
      bus.dataIn   = d;
   endtask

   localparam logic [31:0] D = 32'h44A5_2211;   // ch0=11 ch1=22 ch2=A5 ch3=44

   initial begin
      drive(1'b1, 1'b1, 1'b1, 2'd0, 4'b1111, D);

      // rst en md sel vin data | data valid sel count ptr
      vec.push_back('{1, 1, 1, 0, 4'b1111, D, 8'h00, 0, 0, 8'd0,  0});
      vec.push_back('{1, 1, 1, 0, 4'b1111, D, 8'h00, 0, 0, 8'd0,  0});
      vec.push_back('{0, 1, 0, 2, 4'b0100, D, 8'hA5, 1, 2, 8'd1,  0});
      vec.push_back('{1, 1, 1, 0, 4'b1111, D, 8'h00, 0, 0, 8'd0,  0});
      vec.push_back('{0, 1, 1, 0, 4'b1111, D, 8'h11, 1, 0, 8'd1,  1});
      vec.push_back('{0, 1, 1, 0, 4'b1111, D, 8'h22, 1, 1, 8'd2,  2});
      vec.push_back('{0, 1, 1, 0, 4'b1111, D, 8'hA5, 1, 2, 8'd3,  3});
      vec.push_back('{0, 1, 1, 0, 4'b1111, D, 8'h44, 1, 3, 8'd4,  0});
      vec.push_back('{0, 1, 1, 0, 4'b1111, D, 8'h11, 1, 0, 8'd5,  1});
      vec.push_back('{0, 1, 1, 0, 4'b1111, D, 8'h22, 1, 1, 8'd6,  2});
      vec.push_back('{0, 0, 1, 0, 4'b1111, D, 8'h22, 1, 1, 8'd6,  2});
      vec.push_back('{0, 0, 1, 0, 4'b1111, D, 8'h22, 1, 1, 8'd6,  2});
      vec.push_back('{0, 0, 1, 0, 4'b1111, D, 8'h22, 1, 1, 8'd6,  2});
      vec.push_back('{0, 1, 1, 0, 4'b1111, D, 8'hA5, 1, 2, 8'd7,  3});
      vec.push_back('{0, 1, 1, 0, 4'b0100, D, 8'hA5, 1, 2, 8'd8,  3});
      vec.push_back('{0, 1, 1, 0, 4'b0000, D, 8'hA5, 0, 2, 8'd8,  3});
      vec.push_back('{0, 1, 1, 0, 4'b0001, D, 8'h11, 1, 0, 8'd9,  1});
      vec.push_back('{0, 1, 0, 3, 4'b0000, D, 8'h44, 0, 3, 8'd9,  1});
      vec.push_back('{0, 1, 1, 0, 4'b1111, D, 8'h22, 1, 1, 8'd10, 2});
      vec.push_back('{1, 1, 1, 0, 4'b1111, D, 8'h00, 0, 0, 8'd0,  0});
      vec.push_back('{0, 1, 1, 0, 4'b1111, D, 8'h11, 1, 0, 8'd1,  1});

      foreach (vec[n]) begin
         drive(vec[n].rst, vec[n].en, vec[n].md, vec[n].sel, vec[n].vin, vec[n].data);
         tick();
         chk($sformatf("vec%0d.dataOut", n),    32'(bus.dataOut),    32'(vec[n].eData));
         chk($sformatf("vec%0d.validOut", n),   32'(bus.validOut),   32'(vec[n].eValid));
         chk($sformatf("vec%0d.selOut", n),     32'(bus.selOut),     32'(vec[n].eSel));
         chk($sformatf("vec%0d.grantCount", n), 32'(bus.grantCount), 32'(vec[n].eCount));
         chk($sformatf("vec%0d.ptr", n),        32'(dut.ptr),        32'(vec[n].ePtr));
      end

      // grantCount wrap: 255 valid loads then one more returns to 0.
      drive(1'b1, 1'b1, 1'b0, 2'd1, 4'b0010, D);
      tick();
      drive(1'b0, 1'b1, 1'b0, 2'd1, 4'b0010, D);
      repeat (255) tick();
      chk("wrap.count255", 32'(bus.grantCount), 32'd255);
      tick();
      chk("wrap.count0", 32'(bus.grantCount), 32'd0);
      checkModel("wrap");

      // Reset dominates enable=0.
      drive(1'b1, 1'b0, 1'b1, 2'd3, 4'b1111, D);
      tick();
      chk("rstdom.dataOut",  32'(bus.dataOut),  32'd0);
      chk("rstdom.validOut", 32'(bus.validOut), 32'd0);
      chk("rstdom.selOut",   32'(bus.selOut),   32'd0);
      checkModel("rstdom");

      // Randomized run against the reference model.
      for (int t = 0; t < 3000; t++) begin
         drive(($urandom % 40) == 0,
               ($urandom % 4) != 0,
               1'($urandom),
               2'($urandom),
               (($urandom % 5) == 0) ? 4'b0000 : 4'($urandom),
               $urandom);
         tick();
         checkModel($sformatf("rand%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
